sync_clk_tracker: RTL and testbench



---
 rtl/sync_clk_tracker_if.sv | 35 +++
 rtl/sync_clk_tracker.sv | 218 +++++++++++++++++++++
 tb/tb_sync_clk_tracker.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_clk_tracker_if.sv
// Host-sync bundle between the Sigma Delta DAQ host clock tracker and its
// neighbours. The master side drives the host toggle and error-clear lines.
// The slave side (the tracker) returns the aligned counter and the lock and
// error status.
interface sync_clk_tracker_if #(
    parameter int COUNTER_SIZE = 20
);
    logic                    resetCyclic;
    logic                    clearError;
    logic [COUNTER_SIZE-1:0] syncCounter;
    logic                    errorFlag;
    logic                    locked;
    logic [7:0]              errorCount;
    logic [COUNTER_SIZE-1:0] lastPeriod;

    modport master (
        output resetCyclic,
        output clearError,
        input  syncCounter,
        input  errorFlag,
        input  locked,
        input  errorCount,
        input  lastPeriod
    );

    modport slave (
        input  resetCyclic,
        input  clearError,
        output syncCounter,
        output errorFlag,
        output locked,
        output errorCount,
        output lastPeriod
    );
endinterface

// File: rtl/sync_clk_tracker.sv
// Host clock tracker for the Sigma Delta DAQ.
// The host toggles resetCyclic once per sample interval. This block
// synchronises that line into the local clock domain and zeroes a local
// sample counter at every toggle. It judges each measured period against a
// tolerance window and runs an UNSYNC/ACQUIRE/LOCKED state machine with
// hysteresis. Errors are reported through a sticky flag and a saturating
// counter, which a synchronised clearError rising edge resets.
module sync_clk_tracker #(
    parameter int COUNTER_SIZE   = 20,
    parameter int RESET_INTERVAL = 524287,
    parameter int TOLERANCE      = 2,
    parameter int LOCK_COUNT     = 2,
    parameter int LOSS_COUNT     = 3,
    parameter int SYNC_STAGES    = 3
) (
    input logic               clk,
    input logic               reset,
    sync_clk_tracker_if.slave bus
);

    // The good/bad counters must hold whichever hysteresis target is larger.
    localparam int CNT_MAX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // These are the period window edges. The miss point lies one count past
    // the top of the window.
    localparam logic [COUNTER_SIZE-1:0] LOW_BOUND  = COUNTER_SIZE'(RESET_INTERVAL - TOLERANCE);
    localparam logic [COUNTER_SIZE-1:0] HIGH_BOUND = COUNTER_SIZE'(RESET_INTERVAL + TOLERANCE);
    localparam logic [COUNTER_SIZE-1:0] MISS_VALUE = COUNTER_SIZE'(RESET_INTERVAL + TOLERANCE + 1);

    localparam logic [CNT_W-1:0] LOCK_TARGET = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] LOSS_TARGET = CNT_W'(LOSS_COUNT);

    localparam logic [1:0] S_UNSYNC  = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    logic [SYNC_STAGES-1:0]  rcSync_q;
    logic                    rcHist_q;
    logic [SYNC_STAGES-1:0]  clrSync_q;
    logic                    clrHist_q;

    logic [COUNTER_SIZE-1:0] syncCounter_q, syncCounter_d;
    logic [COUNTER_SIZE-1:0] lastPeriod_q, lastPeriod_d;

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        goodCnt_q, goodCnt_d;
    logic [CNT_W-1:0]        badCnt_q, badCnt_d;
    logic                    locked_q;

    logic                    errorFlag_q, errorFlag_d;
    logic [7:0]              errorCount_q, errorCount_d;

    logic                    toggle;
    logic                    clr;
    logic                    inWindow;
    logic                    goodPeriod;
    logic                    badPeriod;
    logic                    miss;
    logic                    errorEvent;
    logic [CNT_W-1:0]        goodInc;
    logic [CNT_W-1:0]        badInc;

    // Shift both asynchronous inputs through their own synchroniser chains.
    // A history flop behind each chain allows edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rcSync_q  <= '0;
            rcHist_q  <= 1'b0;
            clrSync_q <= '0;
            clrHist_q <= 1'b0;
        end else begin
            rcSync_q  <= {rcSync_q[SYNC_STAGES-2:0], bus.resetCyclic};
            rcHist_q  <= rcSync_q[SYNC_STAGES-1];
            clrSync_q <= {clrSync_q[SYNC_STAGES-2:0], bus.clearError};
            clrHist_q <= clrSync_q[SYNC_STAGES-1];
        end
    end

    assign toggle = rcSync_q[SYNC_STAGES-1] != rcHist_q;
    assign clr    = clrSync_q[SYNC_STAGES-1] & ~clrHist_q;

    // Classify the counter value seen on a toggle, and detect overdue toggles.
    always_comb begin
        inWindow   = (syncCounter_q >= LOW_BOUND) && (syncCounter_q <= HIGH_BOUND);
        goodPeriod = toggle && inWindow;
        badPeriod  = toggle && !inWindow;
        miss       = !toggle && (syncCounter_q == MISS_VALUE);
    end

    assign goodInc = goodCnt_q + CNT_W'(1);
    assign badInc  = badCnt_q + CNT_W'(1);

    // On a toggle, restart the sample counter and capture its old value as
    // the measured period. Otherwise let it run and wrap.
    always_comb begin
        syncCounter_d = syncCounter_q + COUNTER_SIZE'(1);
        lastPeriod_d  = lastPeriod_q;
        if (toggle) begin
            syncCounter_d = '0;
            lastPeriod_d  = syncCounter_q;
        end
    end

    // Register the sample counter and the captured period.
    always_ff @(posedge clk) begin
        if (reset) begin
            syncCounter_q <= '0;
            lastPeriod_q  <= '0;
        end else begin
            syncCounter_q <= syncCounter_d;
            lastPeriod_q  <= lastPeriod_d;
        end
    end

    // Lock state machine. The good/bad counters provide hysteresis, so a
    // single stray period neither grants nor drops lock.
    always_comb begin
        state_d    = state_q;
        goodCnt_d  = goodCnt_q;
        badCnt_d   = badCnt_q;
        errorEvent = 1'b0;
        case (state_q)
            S_UNSYNC: begin
                if (toggle) begin
                    state_d   = S_ACQUIRE;
                    goodCnt_d = '0;
                    badCnt_d  = '0;
                end else if (miss && (badCnt_q < LOSS_TARGET)) begin
                    badCnt_d = badInc;
                    if (badInc == LOSS_TARGET) begin
                        errorEvent = 1'b1;
                    end
                end
            end
            S_ACQUIRE: begin
                if (goodPeriod) begin
                    goodCnt_d = goodInc;
                    if (goodInc == LOCK_TARGET) begin
                        state_d  = S_LOCKED;
                        badCnt_d = '0;
                    end
                end else if (badPeriod || miss) begin
                    goodCnt_d = '0;
                end
            end
            S_LOCKED: begin
                if (goodPeriod) begin
                    badCnt_d = '0;
                end else if (badPeriod || miss) begin
                    errorEvent = 1'b1;
                    if (badInc == LOSS_TARGET) begin
                        state_d   = S_ACQUIRE;
                        goodCnt_d = '0;
                        badCnt_d  = '0;
                    end else begin
                        badCnt_d = badInc;
                    end
                end
            end
            default: begin
                state_d   = S_UNSYNC;
                goodCnt_d = '0;
                badCnt_d  = '0;
            end
        endcase
    end

    // Register the FSM. The locked output is registered from the next state,
    // so it changes on the same clock as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_UNSYNC;
            goodCnt_q <= '0;
            badCnt_q  <= '0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            goodCnt_q <= goodCnt_d;
            badCnt_q  <= badCnt_d;
            locked_q  <= (state_d == S_LOCKED);
        end
    end

    // Error reporting. A clear wins over an error in the same cycle, and the
    // error count sticks at its maximum value.
    always_comb begin
        errorFlag_d  = errorFlag_q;
        errorCount_d = errorCount_q;
        if (clr) begin
            errorFlag_d  = 1'b0;
            errorCount_d = '0;
        end else if (errorEvent) begin
            errorFlag_d = 1'b1;
            if (errorCount_q != 8'hFF) begin
                errorCount_d = errorCount_q + 8'd1;
            end
        end
    end

    // Register the error flag and the error count.
    always_ff @(posedge clk) begin
        if (reset) begin
            errorFlag_q  <= 1'b0;
            errorCount_q <= '0;
        end else begin
            errorFlag_q  <= errorFlag_d;
            errorCount_q <= errorCount_d;
        end
    end

    assign bus.syncCounter = syncCounter_q;
    assign bus.lastPeriod  = lastPeriod_q;
    assign bus.errorFlag   = errorFlag_q;
    assign bus.errorCount  = errorCount_q;
    assign bus.locked      = locked_q;

endmodule

// File: tb/tb_sync_clk_tracker.sv
// Testbench for sync_clk_tracker using the small-parameter configuration.
// Directed host toggle sequences drive the design. A cycle-level reference
// model predicts every output, and literal expectations pin key moments.
module tb_sync_clk_tracker;

    localparam int CS   = 8;
    localparam int RI   = 20;
    localparam int TOL  = 1;
    localparam int LOCK = 2;
    localparam int LOSS = 3;
    localparam int SS   = 2;

    logic clk;
    logic reset;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    sync_clk_tracker_if #(.COUNTER_SIZE(CS)) bus ();

    sync_clk_tracker #(
        .COUNTER_SIZE  (CS),
        .RESET_INTERVAL(RI),
        .TOLERANCE     (TOL),
        .LOCK_COUNT    (LOCK),
        .LOSS_COUNT    (LOSS),
        .SYNC_STAGES   (SS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so that messages can name the cycle.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic compareField(input string name, input logic [31:0] actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference model state. Inputs are as sampled at the previous rising
    // edge. rcH[k] and ceH[k] hold the line level seen k+1 edges ago.
    logic pReset = 1'b1;
    logic pRc    = 1'b0;
    logic pCe    = 1'b0;
    bit   rcH[SS+1];
    bit   ceH[SS+1];
    int   mCnt = 0, mLast = 0, mState = 0, mGood = 0, mBad = 0, mErrCnt = 0;
    bit   mFlag = 0;

    // Advance the model by the rising edge just passed. Then compare every
    // output against the model.
    always @(negedge clk) begin
        bit tog, clr, good, miss, err;
        int p;
        if (pReset) begin
            mCnt = 0; mLast = 0; mState = 0; mGood = 0; mBad = 0; mErrCnt = 0; mFlag = 0;
            for (int k = 0; k <= SS; k++) begin
                rcH[k] = 0;
                ceH[k] = 0;
            end
        end else begin
            tog  = rcH[SS-1] != rcH[SS];
            clr  = ceH[SS-1] && !ceH[SS];
            p    = mCnt;
            good = (p >= RI - TOL) && (p <= RI + TOL);
            miss = !tog && (p == RI + TOL + 1);
            err  = 0;
            if (mState == 0) begin
                if (tog) begin
                    mState = 1; mGood = 0; mBad = 0;
                end else if (miss && mBad < LOSS) begin
                    mBad++;
                    if (mBad == LOSS) err = 1;
                end
            end else if (mState == 1) begin
                if (tog && good) begin
                    mGood++;
                    if (mGood == LOCK) begin
                        mState = 2; mBad = 0;
                    end
                end else if (tog || miss) begin
                    mGood = 0;
                end
            end else begin
                if (tog && good) begin
                    mBad = 0;
                end else if (tog || miss) begin
                    err = 1;
                    mBad++;
                    if (mBad == LOSS) begin
                        mState = 1; mGood = 0; mBad = 0;
                    end
                end
            end
            if (tog) begin
                mLast = p;
                mCnt  = 0;
            end else begin
                mCnt = (mCnt + 1) % (1 << CS);
            end
            if (clr) begin
                mFlag = 0; mErrCnt = 0;
            end else if (err) begin
                mFlag = 1;
                if (mErrCnt < 255) mErrCnt++;
            end
            for (int k = SS; k > 0; k--) begin
                rcH[k] = rcH[k-1];
                ceH[k] = ceH[k-1];
            end
            rcH[0] = pRc;
            ceH[0] = pCe;
        end
        compareField("model syncCounter", 32'(bus.syncCounter), mCnt);
        compareField("model lastPeriod", 32'(bus.lastPeriod), mLast);
        compareField("model errorFlag", 32'(bus.errorFlag), int'(mFlag));
        compareField("model errorCount", 32'(bus.errorCount), mErrCnt);
        compareField("model locked", 32'(bus.locked), (mState == 2) ? 1 : 0);
        pReset = reset;
        pRc    = bus.resetCyclic;
        pCe    = bus.clearError;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Flip the host toggle line, then wait the given number of clocks.
    task automatic applyStimulus(input int gap);
        bus.resetCyclic = ~bus.resetCyclic;
        tick(gap);
    endtask

    // Check literal expectations. A negative expectation means don't care.
    task automatic checkOutput(input string name, input int expSync, input int expLast,
                               input int expFlag, input int expCnt, input int expLocked);
        if (expSync >= 0)   compareField({name, " syncCounter"}, 32'(bus.syncCounter), expSync);
        if (expLast >= 0)   compareField({name, " lastPeriod"}, 32'(bus.lastPeriod), expLast);
        if (expFlag >= 0)   compareField({name, " errorFlag"}, 32'(bus.errorFlag), expFlag);
        if (expCnt >= 0)    compareField({name, " errorCount"}, 32'(bus.errorCount), expCnt);
        if (expLocked >= 0) compareField({name, " locked"}, 32'(bus.locked), expLocked);
    endtask

    initial begin
        reset           = 1'b1;
        bus.resetCyclic = 1'b0;
        bus.clearError  = 1'b0;
        tick(3);
        checkOutput("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick(5);

        $display("[TB] scenario 1: acquire and lock");
        applyStimulus(3);
        checkOutput("s1 t1", 0, 7, 0, 0, 0);
        tick(18);
        applyStimulus(3);
        checkOutput("s1 t2", 0, 20, 0, 0, 0);
        tick(18);
        applyStimulus(3);
        checkOutput("s1 t3", 0, 20, 0, 0, 1);

        $display("[TB] scenario 2: short then long-in-tolerance period");
        tick(16);
        applyStimulus(3);
        checkOutput("s2 short", 0, 18, 1, 1, 1);
        tick(19);
        applyStimulus(3);
        checkOutput("s2 long", 0, 21, 1, 1, 1);
        tick(18);
        applyStimulus(3);
        checkOutput("s2 nominal", 0, 20, 1, 1, 1);

        $display("[TB] clear errors while idle");
        bus.clearError = 1'b1;
        tick(3);
        checkOutput("clear", 3, 20, 0, 0, 1);
        bus.clearError = 1'b0;

        $display("[TB] scenario 3: lose lock through misses");
        tick(19);
        checkOutput("s3 before miss", 22, 20, 0, 0, 1);
        tick(1);
        checkOutput("s3 miss1", 23, 20, 1, 1, 1);
        tick(512);
        checkOutput("s3 miss3", 23, 20, 1, 3, 0);

        $display("[TB] scenario 4: misses while unsynchronised");
        reset           = 1'b1;
        bus.resetCyclic = 1'b0;
        tick(2);
        checkOutput("s4 reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick(100);
        checkOutput("s4 one miss", 100, 0, 0, 0, 0);
        tick(500);
        checkOutput("s4 three misses", 88, 0, 1, 1, 0);
        tick(256);
        checkOutput("s4 extra miss", 88, 0, 1, 1, 0);

        $display("[TB] scenario 5: clear coincides with bad toggle");
        applyStimulus(3);
        checkOutput("s5 t1", 0, 90, 1, 1, 0);
        tick(18);
        applyStimulus(21);
        applyStimulus(3);
        checkOutput("s5 locked", 0, 20, 1, 1, 1);
        tick(12);
        bus.clearError = 1'b1;
        applyStimulus(3);
        checkOutput("s5 clear vs bad", 0, 14, 0, 0, 1);
        bus.clearError = 1'b0;
        tick(18);

        $display("[TB] scenario 6: reset while locked with errors");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(19);
            applyStimulus(21);
        end
        applyStimulus(3);
        checkOutput("s6 five errors", 0, 20, 1, 5, 1);
        reset           = 1'b1;
        bus.resetCyclic = 1'b0;
        tick(1);
        checkOutput("s6 after reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick(4);
        applyStimulus(3);
        checkOutput("s6 relock t1", 0, 6, 0, 0, 0);
        tick(18);
        applyStimulus(3);
        checkOutput("s6 relock t2", 0, 20, 0, 0, 0);
        tick(18);
        applyStimulus(3);
        checkOutput("s6 relock t3", 0, 20, 0, 0, 1);
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
